// File: rtl/c3lib_sync_pkg.sv
// Shared limits and helpers for the filtered bit-synchronizer family.
package c3lib_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 5;
  localparam int FILT_CNT_MAX    = 255;

  // Bypass and single-cycle filters still get a 1-bit counter so widths stay legal.
  function automatic int cnt_width(input int filt_cnt);
    int span;
    span = (filt_cnt > 2) ? filt_cnt : 2;
    return $clog2(span);
  endfunction

endpackage

// File: rtl/c3lib_sync_filt_bit.sv
// One synchronized, glitch-filtered bit with registered edge pulses and busy flag.
module c3lib_sync_filt_bit
  import c3lib_sync_pkg::*;
#(
  parameter int   SYNC_STAGES = 3,
  parameter logic RESET_BIT   = 1'b0,
  parameter int   FILT_CNT    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out,
  output logic rise_pls,
  output logic fall_pls,
  output logic filt_busy
);

  localparam int             CW       = cnt_width(FILT_CNT);
  localparam logic [CW-1:0]  CNT_LAST = CW'((FILT_CNT > 0) ? (FILT_CNT - 1) : 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;

  // Pure flop chain: nothing sits between stages so it can be constrained as a synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Qualification: a new level must persist FILT_CNT cycles before it is accepted.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (FILT_CNT == 0) begin
      out_d = sync_s;
    end else if (sync_s != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = sync_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
    busy_d = (cnt_d != '0);
  end

  // Output and filter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= RESET_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      busy_q <= busy_d;
    end
  end

  assign data_out  = out_q;
  assign rise_pls  = rise_q;
  assign fall_pls  = fall_q;
  assign filt_busy = busy_q;

endmodule

// File: rtl/c3lib_sync_filt_bitsync.sv
// Multi-bit wrapper: DWIDTH independent filtered synchronizers, no cross-bit coherency.
module c3lib_sync_filt_bitsync
  import c3lib_sync_pkg::*;
#(
  parameter int DWIDTH      = 1,
  parameter int SYNC_STAGES = 3,
  parameter int RESET_VAL   = 0,
  parameter int FILT_CNT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic [DWIDTH-1:0] rise_pls,
  output logic [DWIDTH-1:0] fall_pls,
  output logic [DWIDTH-1:0] filt_busy
);

  localparam logic RESET_BIT = (RESET_VAL != 0);

  if (DWIDTH < 1) begin : g_bad_dwidth
    $error("c3lib_sync_filt_bitsync: DWIDTH must be at least 1");
  end
  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
    $error("c3lib_sync_filt_bitsync: SYNC_STAGES out of range 2..5");
  end
  if ((FILT_CNT < 0) || (FILT_CNT > FILT_CNT_MAX)) begin : g_bad_filt
    $error("c3lib_sync_filt_bitsync: FILT_CNT out of range 0..255");
  end

  for (genvar i = 0; i < DWIDTH; i++) begin : g_bit
    c3lib_sync_filt_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_BIT   (RESET_BIT),
      .FILT_CNT    (FILT_CNT)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in[i]),
      .data_out  (data_out[i]),
      .rise_pls  (rise_pls[i]),
      .fall_pls  (fall_pls[i]),
      .filt_busy (filt_busy[i])
    );
  end

endmodule

// File: tb/tb_c3lib_sync_filt_bitsync.sv
// Scoreboard bench: four configurations share clk/rst; each edge pulse is matched against a queued expectation.
module tb_c3lib_sync_filt_bitsync;

  typedef struct packed {
    int   inst;
    int   bitn;
    logic rise;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       d0, d1, d3;
  logic [3:0] d2;
  logic       o0, r0, f0, b0;
  logic       o1, r1, f1, b1;
  logic [3:0] o2, r2, f2, b2;
  logic       o3, r3, f3, b3;

  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  c3lib_sync_filt_bitsync #(.DWIDTH(1), .SYNC_STAGES(3), .RESET_VAL(0), .FILT_CNT(4)) u0 (
    .clk(clk), .rst(rst), .data_in(d0), .data_out(o0), .rise_pls(r0), .fall_pls(f0), .filt_busy(b0));
  c3lib_sync_filt_bitsync #(.DWIDTH(1), .SYNC_STAGES(2), .RESET_VAL(1), .FILT_CNT(0)) u1 (
    .clk(clk), .rst(rst), .data_in(d1), .data_out(o1), .rise_pls(r1), .fall_pls(f1), .filt_busy(b1));
  c3lib_sync_filt_bitsync #(.DWIDTH(4), .SYNC_STAGES(3), .RESET_VAL(0), .FILT_CNT(2)) u2 (
    .clk(clk), .rst(rst), .data_in(d2), .data_out(o2), .rise_pls(r2), .fall_pls(f2), .filt_busy(b2));
  c3lib_sync_filt_bitsync #(.DWIDTH(1), .SYNC_STAGES(3), .RESET_VAL(1), .FILT_CNT(4)) u3 (
    .clk(clk), .rst(rst), .data_in(d3), .data_out(o3), .rise_pls(r3), .fall_pls(f3), .filt_busy(b3));

  task automatic expect_pulse(input int inst, input int bitn, input logic rise, input int lat);
    exp_t e;
    e.inst = inst;
    e.bitn = bitn;
    e.rise = rise;
    e.cyc  = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic scan();
    logic [3:0] rv [4];
    logic [3:0] fv [4];
    exp_t a, e;
    rv[0] = {3'b000, r0}; fv[0] = {3'b000, f0};
    rv[1] = {3'b000, r1}; fv[1] = {3'b000, f1};
    rv[2] = r2;           fv[2] = f2;
    rv[3] = {3'b000, r3}; fv[3] = {3'b000, f3};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ((rv[i] & fv[i]) !== 4'b0000) begin
        n_err++;
        $display("FAIL both_pulses inst%0d cyc=%0d rise=%b fall=%b required no overlap", i, cyc, rv[i], fv[i]);
      end
      for (int b = 0; b < 4; b++) begin
        for (int k = 0; k < 2; k++) begin
          if ((k == 0) ? (rv[i][b] === 1'b1) : (fv[i][b] === 1'b1)) begin
            a.inst = i;
            a.bitn = b;
            a.rise = (k == 0);
            a.cyc  = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_pulse inst%0d bit%0d rise=%0b cyc=%0d required none", i, b, a.rise, cyc);
            end else begin
              e = exp_q.pop_front();
              if (a !== e) begin
                n_err++;
                $display("FAIL pulse got inst%0d bit%0d rise=%0b cyc=%0d required inst%0d bit%0d rise=%0b cyc=%0d",
                         a.inst, a.bitn, a.rise, a.cyc, e.inst, e.bitn, e.rise, e.cyc);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      scan();
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s missing_pulses pending=%0d required 0 (next due cyc %0d)", name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; d0 = 1'b0; d1 = 1'b1; d2 = 4'b0000; d3 = 1'b1;
    step(3);
    n_cmp++;
    if ({o0, r0, f0, b0} !== 4'b0000) begin
      n_err++; $display("FAIL reset_u0 got %b required 0000", {o0, r0, f0, b0});
    end
    n_cmp++;
    if ({o1, r1, f1, b1} !== 4'b1000) begin
      n_err++; $display("FAIL reset_u1 got %b required 1000", {o1, r1, f1, b1});
    end
    n_cmp++;
    if ({o2, r2, f2, b2} !== 16'h0000) begin
      n_err++; $display("FAIL reset_u2 got %h required 0000", {o2, r2, f2, b2});
    end
    n_cmp++;
    if ({o3, r3, f3, b3} !== 4'b1000) begin
      n_err++; $display("FAIL reset_u3 got %b required 1000", {o3, r3, f3, b3});
    end
    rst = 1'b0;
    step(10);
    n_cmp++;
    if ({o0, o1, o2, o3} !== 7'b0100001) begin
      n_err++; $display("FAIL post_reset_levels got %b required 0100001", {o0, o1, o2, o3});
    end
    check_drained("reset");
  endtask

  task automatic test_glitch();
    int busy_cnt = 0;
    int out_cnt  = 0;
    d0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 3) d0 = 1'b0;
      if (b0 === 1'b1) busy_cnt++;
      if (o0 !== 1'b0) out_cnt++;
      if (k == 6) begin
        n_cmp++;
        if (b0 !== 1'b1) begin
          n_err++; $display("FAIL glitch_busy_k6 got %b required 1", b0);
        end
      end
      if (k == 7) begin
        n_cmp++;
        if (b0 !== 1'b0) begin
          n_err++; $display("FAIL glitch_busy_k7 got %b required 0", b0);
        end
      end
    end
    n_cmp++;
    if (busy_cnt != 3) begin
      n_err++; $display("FAIL glitch_busy_cycles got %0d required 3", busy_cnt);
    end
    n_cmp++;
    if (out_cnt != 0) begin
      n_err++; $display("FAIL glitch_data_out got %0d high cycles required 0", out_cnt);
    end
    check_drained("glitch");
  endtask

  task automatic test_rise_held();
    d0 = 1'b1;
    expect_pulse(0, 0, 1'b1, 7);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 3) begin
        n_cmp++;
        if (b0 !== 1'b0) begin
          n_err++; $display("FAIL rise_busy_k3 got %b required 0", b0);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (b0 !== 1'b1) begin
          n_err++; $display("FAIL rise_busy_k4 got %b required 1", b0);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if ({o0, b0} !== 2'b01) begin
          n_err++; $display("FAIL rise_k6 out/busy got %b required 01", {o0, b0});
        end
      end
      if (k == 7) begin
        n_cmp++;
        if ({o0, b0} !== 2'b10) begin
          n_err++; $display("FAIL rise_k7 out/busy got %b required 10", {o0, b0});
        end
      end
    end
    check_drained("rise_held");
  endtask

  task automatic test_back_to_back();
    d0 = 1'b0;
    expect_pulse(0, 0, 1'b0, 7);
    step(6);
    n_cmp++;
    if (o0 !== 1'b1) begin
      n_err++; $display("FAIL b2b_fall_early got %b required 1", o0);
    end
    step(1);
    n_cmp++;
    if (o0 !== 1'b0) begin
      n_err++; $display("FAIL b2b_fall got %b required 0", o0);
    end
    step(5);
    check_drained("back_to_back");
  endtask

  task automatic test_reset_mid_qual();
    d0 = 1'b1;
    step(6);
    n_cmp++;
    if ({o0, b0} !== 2'b01) begin
      n_err++; $display("FAIL midq_before_rst got %b required 01", {o0, b0});
    end
    rst = 1'b1;
    step(2);
    n_cmp++;
    if ({o0, b0} !== 2'b00) begin
      n_err++; $display("FAIL midq_in_rst got %b required 00", {o0, b0});
    end
    rst = 1'b0;
    expect_pulse(0, 0, 1'b1, 7);
    step(6);
    n_cmp++;
    if (o0 !== 1'b0) begin
      n_err++; $display("FAIL midq_early got %b required 0", o0);
    end
    step(1);
    n_cmp++;
    if (o0 !== 1'b1) begin
      n_err++; $display("FAIL midq_update got %b required 1", o0);
    end
    step(5);
    check_drained("reset_mid_qual");
  endtask

  task automatic test_filt_bypass();
    d1 = 1'b0;
    expect_pulse(1, 0, 1'b0, 3);
    step(2);
    n_cmp++;
    if (o1 !== 1'b1) begin
      n_err++; $display("FAIL bypass_early got %b required 1", o1);
    end
    step(1);
    n_cmp++;
    if (o1 !== 1'b0) begin
      n_err++; $display("FAIL bypass_fall got %b required 0", o1);
    end
    d1 = 1'b1;
    expect_pulse(1, 0, 1'b1, 3);
    step(3);
    n_cmp++;
    if (o1 !== 1'b1) begin
      n_err++; $display("FAIL bypass_rise got %b required 1", o1);
    end
    step(3);
    check_drained("filt_bypass");
  endtask

  task automatic test_bit_isolation();
    d2 = 4'b0100;
    expect_pulse(2, 2, 1'b1, 5);
    step(4);
    n_cmp++;
    if (o2 !== 4'b0000) begin
      n_err++; $display("FAIL iso_early got %b required 0000", o2);
    end
    step(1);
    n_cmp++;
    if (o2 !== 4'b0100) begin
      n_err++; $display("FAIL iso_rise got %b required 0100", o2);
    end
    step(3);
    d2 = 4'b0000;
    expect_pulse(2, 2, 1'b0, 5);
    step(8);
    n_cmp++;
    if (o2 !== 4'b0000) begin
      n_err++; $display("FAIL iso_fall got %b required 0000", o2);
    end
    check_drained("bit_isolation");
  endtask

  task automatic test_rv_high_release();
    rst = 1'b1; d0 = 1'b0; d3 = 1'b0;
    step(4);
    n_cmp++;
    if ({o3, f3, o0} !== 3'b100) begin
      n_err++; $display("FAIL rvh_in_rst got %b required 100", {o3, f3, o0});
    end
    rst = 1'b0;
    expect_pulse(3, 0, 1'b0, 7);
    step(6);
    n_cmp++;
    if (o3 !== 1'b1) begin
      n_err++; $display("FAIL rvh_early got %b required 1", o3);
    end
    step(1);
    n_cmp++;
    if (o3 !== 1'b0) begin
      n_err++; $display("FAIL rvh_fall got %b required 0", o3);
    end
    step(5);
    check_drained("rv_high_release");
  endtask

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    d0 = 1'b0; d1 = 1'b1; d2 = 4'b0000; d3 = 1'b1;
    test_reset();
    test_glitch();
    test_rise_held();
    test_back_to_back();
    test_reset_mid_qual();
    test_filt_bypass();
    test_bit_isolation();
    test_rv_high_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
